// File: rtl/result_writer.sv
// rtl/result_writer.sv - packs filtered 8-bit pixels MSB-first into 32-bit words and writes them to the BRAM result region
module result_writer #(
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR  = 32'hB000_1000,
  parameter int                  PIXEL_SIZE     = 8,
  parameter int                  IMAGE_SIZE     = 676,
  parameter int                  TOT_NUM_IMAGES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PIXEL_SIZE-1:0] pixel_in,
  input  logic                  pixel_in_valid,
  output logic                  pixel_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic                  busy,
  output logic                  done
);

  localparam int PIX_W = $clog2(IMAGE_SIZE + 1);
  localparam int IMG_W = $clog2(TOT_NUM_IMAGES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_t;

  state_t                state;
  logic                  prev_start;
  logic [1:0]            index_count;
  logic [PIX_W-1:0]      pixel_count;
  logic [IMG_W-1:0]      image_count;
  logic [DATA_WIDTH-1:0] pack_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr;

  logic                  start_edge;
  logic                  accept;
  logic                  image_last;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0] merged_word;

  assign pixel_ready = (state == ST_COLLECT);
  assign start_edge  = start && !prev_start;
  assign accept      = pixel_ready && pixel_in_valid;
  assign image_last  = (pixel_count == PIX_W'(IMAGE_SIZE - 1));
  assign word_done   = (index_count == 2'd3) || image_last;

  // Lane 0 is the most significant byte so the reader's unpacking matches.
  always_comb begin
    lane_word   = {pixel_in, {(DATA_WIDTH-PIXEL_SIZE){1'b0}}} >> (32'(index_count) * PIXEL_SIZE);
    merged_word = pack_reg | lane_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      prev_start  <= 1'b0;
      index_count <= '0;
      pixel_count <= '0;
      image_count <= '0;
      pack_reg    <= '0;
      wr_ptr      <= '0;
      bram_addr   <= '0;
      bram_din    <= '0;
      bram_en     <= 1'b0;
      bram_we     <= 4'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      prev_start <= start;
      bram_en    <= 1'b0;
      bram_we    <= 4'h0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            state       <= ST_COLLECT;
            index_count <= '0;
            pixel_count <= '0;
            image_count <= '0;
            pack_reg    <= '0;
            wr_ptr      <= RESULT_ADDR;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            if (word_done) begin
              // Completed word goes out; the pack register restarts empty so
              // a short final word of an image has zeroed trailing lanes.
              bram_din    <= merged_word;
              bram_addr   <= wr_ptr;
              bram_en     <= 1'b1;
              bram_we     <= 4'hF;
              wr_ptr      <= wr_ptr + ADDR_WIDTH'(4);
              pack_reg    <= '0;
              index_count <= '0;
            end else begin
              pack_reg    <= merged_word;
              index_count <= index_count + 2'd1;
            end
            if (image_last) begin
              pixel_count <= '0;
              image_count <= image_count + IMG_W'(1);
              if (image_count == IMG_W'(TOT_NUM_IMAGES - 1)) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              pixel_count <= pixel_count + PIX_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// tb/tb_result_writer.sv - directed checks of result_writer packing, addressing, timing and reset
module tb_result_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;

  logic        ready8, en8, busy8, done8;
  logic [31:0] addr8, din8;
  logic [3:0]  we8;
  logic        ready6, en6, busy6, done6;
  logic [31:0] addr6, din6;
  logic [3:0]  we6;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] q8_addr[$], q8_data[$], q6_addr[$], q6_data[$];

  always #5 clk = ~clk;

  result_writer #(.IMAGE_SIZE(8), .TOT_NUM_IMAGES(1)) dut8 (
    .clk(clk), .reset(reset), .start(start), .pixel_in(pixel_in),
    .pixel_in_valid(pixel_in_valid), .pixel_ready(ready8), .bram_addr(addr8),
    .bram_din(din8), .bram_en(en8), .bram_we(we8), .busy(busy8), .done(done8)
  );

  result_writer #(.IMAGE_SIZE(6), .TOT_NUM_IMAGES(2)) dut6 (
    .clk(clk), .reset(reset), .start(start), .pixel_in(pixel_in),
    .pixel_in_valid(pixel_in_valid), .pixel_ready(ready6), .bram_addr(addr6),
    .bram_din(din6), .bram_en(en6), .bram_we(we6), .busy(busy6), .done(done6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // Write log, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (en8) begin
      q8_addr.push_back(addr8);
      q8_data.push_back(din8);
      check("we8", 32'(we8), 32'hF);
    end
    if (en6) begin
      q6_addr.push_back(addr6);
      q6_data.push_back(din6);
      check("we6", 32'(we6), 32'hF);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q8_addr.delete(); q8_data.delete(); q6_addr.delete(); q6_data.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic stream8(input int gap, input string tag);
    do_reset();
    clear_logs();
    do_start();
    check({tag, "_ready"}, 32'(ready8), 32'd1);
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pixel_in       = 8'(i + 1);
      pixel_in_valid = 1'b1;
      tick();
      check($sformatf("%s_en%0d", tag, i), 32'(en8), 32'((i == 3) || (i == 7)));
      if (gap > 0) begin
        pixel_in_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    pixel_in_valid = 1'b0;
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_ready_off"}, 32'(ready8), 32'd0);
    check({tag, "_busy_off"}, 32'(busy8), 32'd0);
    repeat (3) tick();
    check({tag, "_nwr"}, 32'(q8_addr.size()), 32'd2);
    check({tag, "_a0"}, q8_addr[0], 32'hB000_1000);
    check({tag, "_d0"}, q8_data[0], 32'h0102_0304);
    check({tag, "_a1"}, q8_addr[1], 32'hB000_1004);
    check({tag, "_d1"}, q8_data[1], 32'h0506_0708);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pixel_in = '0; pixel_in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_logs();

    // Asynchronous reset applied mid-cycle.
    #3 reset = 1'b1;
    #1;
    check("rst_addr", addr8, 32'h0);
    check("rst_din", din8, 32'h0);
    check("rst_en", 32'(en8), 32'h0);
    check("rst_we", 32'(we8), 32'h0);
    check("rst_busy", 32'(busy8), 32'h0);
    check("rst_done", 32'(done8), 32'h0);
    check("rst_ready", 32'(ready8), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    pixel_in = 8'h55; pixel_in_valid = 1'b1;
    repeat (4) tick();
    check("nostart_ready", 32'(ready8), 32'h0);
    pixel_in_valid = 1'b0;
    tick();
    check("nostart_nwr", 32'(q8_addr.size()), 32'd0);

    stream8(0, "b2b");
    stream8(2, "gap");

    // Two 6-pixel images: each ends on a short, zero-padded word.
    do_reset();
    clear_logs();
    do_start();
    for (int i = 0; i < 12; i++) begin
      pixel_in       = (i < 6) ? 8'(8'hA1 + i) : 8'(8'hB1 + i - 6);
      pixel_in_valid = 1'b1;
      tick();
    end
    pixel_in_valid = 1'b0;
    check("two_done", 32'(done6), 32'd1);
    repeat (3) tick();
    check("two_nwr", 32'(q6_addr.size()), 32'd4);
    check("two_a0", q6_addr[0], 32'hB000_1000);
    check("two_d0", q6_data[0], 32'hA1A2_A3A4);
    check("two_a1", q6_addr[1], 32'hB000_1004);
    check("two_d1", q6_data[1], 32'hA5A6_0000);
    check("two_a2", q6_addr[2], 32'hB000_1008);
    check("two_d2", q6_data[2], 32'hB1B2_B3B4);
    check("two_a3", q6_addr[3], 32'hB000_100C);
    check("two_d3", q6_data[3], 32'hB5B6_0000);

    // Input ignored after done; new start edge restarts from RESULT_ADDR.
    pixel_in = 8'hFF; pixel_in_valid = 1'b1;
    repeat (4) tick();
    pixel_in_valid = 1'b0;
    tick();
    check("post_done_nwr", 32'(q6_addr.size()), 32'd4);
    check("post_done_hold", 32'(done6), 32'd1);
    do_start();
    check("restart_done", 32'(done6), 32'd0);
    check("restart_busy", 32'(busy6), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pixel_in       = 8'(8'hC1 + i);
      pixel_in_valid = 1'b1;
      tick();
    end
    pixel_in_valid = 1'b0;
    repeat (2) tick();
    check("restart_nwr", 32'(q6_addr.size()), 32'd5);
    check("restart_a", q6_addr[4], 32'hB000_1000);
    check("restart_d", q6_data[4], 32'hC1C2_C3C4);

    // Reset part-way through a word discards it.
    do_reset();
    clear_logs();
    do_start();
    for (int i = 0; i < 3; i++) begin
      pixel_in       = 8'(8'h11 * (i + 1));
      pixel_in_valid = 1'b1;
      tick();
    end
    pixel_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready8), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("abort_nwr", 32'(q8_addr.size()), 32'd0);
    check("abort_en", 32'(en8), 32'd0);
    stream8(0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
